// File: rtl/ff_seq.sv
// ff_seq: chunked find-first-set search over a registered bitmap, starting at req_start.
// Build option: define FF_SEQ_WRAP_EN to continue the search below req_start after the top chunk.
//
// state | meaning
// IDLE  | ready for a request (req_rdy=1)
// SCAN  | one chunk per cycle; fin_q marks the cycle after the result was registered
// DONE  | result presented (resp_val=1) until resp_rdy
module ff_seq #(
   parameter  int WND_WIDTH   = 128,
   parameter  int CHUNK_WIDTH = 16,
   localparam int IND_WIDTH   = $clog2(WND_WIDTH),
   localparam int NUM_CHUNKS  = WND_WIDTH / CHUNK_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_val,
   output logic                 req_rdy,
   input  logic [WND_WIDTH-1:0] req_bitmap,
   input  logic [IND_WIDTH-1:0] req_start,
   output logic                 resp_val,
   input  logic                 resp_rdy,
   output logic                 resp_found,
   output logic [IND_WIDTH-1:0] resp_ind
);

   localparam int OFF_W = $clog2(CHUNK_WIDTH);
   localparam int CP_W  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CP_W-1:0] LAST_CHUNK = CP_W'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t               state_q, state_d;
   logic [WND_WIDTH-1:0] bitmap_q;
   logic [IND_WIDTH-1:0] start_q;
   logic [CP_W-1:0]      chunk_q;
   logic                 fin_q;
   logic                 found_q;
   logic [IND_WIDTH-1:0] ind_q;
`ifdef FF_SEQ_WRAP_EN
   logic                 wrap_q;
`endif

   logic [IND_WIDTH-1:0]   base;
   logic [IND_WIDTH-1:0]   idx;
   logic [IND_WIDTH-1:0]   hit_idx;
   logic [CHUNK_WIDTH-1:0] chunk_bits;
   logic                   hit;
   logic                   last;
   logic                   eligible;

   // Masked priority encode of the current chunk; the lowest eligible bit wins.
   always_comb begin
      base       = IND_WIDTH'(chunk_q) << OFF_W;
      chunk_bits = CHUNK_WIDTH'(bitmap_q >> base);
      hit        = 1'b0;
      hit_idx    = '0;
      idx        = '0;
      eligible   = 1'b0;
      for (int j = CHUNK_WIDTH - 1; j >= 0; j--) begin
         idx = base + IND_WIDTH'(j);
`ifdef FF_SEQ_WRAP_EN
         eligible = wrap_q ? (idx < start_q) : (idx >= start_q);
`else
         eligible = (idx >= start_q);
`endif
         if (chunk_bits[j] && eligible) begin
            hit     = 1'b1;
            hit_idx = idx;
         end
      end
`ifdef FF_SEQ_WRAP_EN
      last = wrap_q && (chunk_q == CP_W'(start_q >> OFF_W));
`else
      last = (chunk_q == LAST_CHUNK);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_val) state_d = SCAN;
         SCAN:    if (fin_q) state_d = DONE;
         DONE:    if (resp_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_rdy    = (state_q == IDLE);
      resp_val   = (state_q == DONE);
      resp_found = found_q;
      resp_ind   = ind_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitmap_q <= '0;
         start_q  <= '0;
         chunk_q  <= '0;
         fin_q    <= 1'b0;
         found_q  <= 1'b0;
         ind_q    <= '0;
`ifdef FF_SEQ_WRAP_EN
         wrap_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (req_val) begin
                  bitmap_q <= req_bitmap;
                  start_q  <= req_start;
                  chunk_q  <= CP_W'(req_start >> OFF_W);
                  fin_q    <= 1'b0;
                  found_q  <= 1'b0;
                  ind_q    <= '0;
`ifdef FF_SEQ_WRAP_EN
                  wrap_q   <= 1'b0;
`endif
               end
            end
            SCAN: begin
               if (!fin_q) begin
                  if (hit) begin
                     found_q <= 1'b1;
                     ind_q   <= hit_idx;
                     fin_q   <= 1'b1;
                  end else if (last) begin
                     found_q <= 1'b0;
                     ind_q   <= '0;
                     fin_q   <= 1'b1;
                  end else begin
                     chunk_q <= (chunk_q == LAST_CHUNK) ? '0 : chunk_q + CP_W'(1);
`ifdef FF_SEQ_WRAP_EN
                     if (chunk_q == LAST_CHUNK) wrap_q <= 1'b1;
`endif
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ff_seq.sv
// Directed bench for ff_seq (128-bit window, 16-bit chunks); expectations follow FF_SEQ_WRAP_EN.
module tb_ff_seq;

   localparam int WW = 128;
   localparam int IW = 7;

   logic          clk;
   logic          rst_n;
   logic          req_val;
   logic          req_rdy;
   logic [WW-1:0] req_bitmap;
   logic [IW-1:0] req_start;
   logic          resp_val;
   logic          resp_rdy;
   logic          resp_found;
   logic [IW-1:0] resp_ind;

   int n_vec = 0;
   int n_err = 0;

   ff_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_val    (req_val),
      .req_rdy    (req_rdy),
      .req_bitmap (req_bitmap),
      .req_start  (req_start),
      .resp_val   (resp_val),
      .resp_rdy   (resp_rdy),
      .resp_found (resp_found),
      .resp_ind   (resp_ind)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // Accept on the next edge (cycle 0), then scramble inputs so only the registered copy can match.
   task automatic issue(input logic [WW-1:0] bm, input int start);
      @(negedge clk);
      req_val    = 1'b1;
      req_bitmap = bm;
      req_start  = IW'(start);
      @(posedge clk);
      #1;
      req_val    = 1'b0;
      req_bitmap = '1;
      req_start  = '0;
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         @(posedge clk);
         #1;
         if (resp_val) lat = c;
      end
   endtask

   task automatic run(input string tag, input logic [WW-1:0] bm, input int start,
                      input int exp_lat, input int exp_found, input int exp_ind);
      int lat;
      issue(bm, start);
      wait_resp(lat);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_found"}, int'(resp_found), exp_found);
      chk({tag, "_ind"}, int'(resp_ind), exp_ind);
      chk({tag, "_rdy_busy"}, int'(req_rdy), 0);
      @(posedge clk);
      #1;
      chk({tag, "_rdy_after"}, int'(req_rdy), 1);
      chk({tag, "_val_after"}, int'(resp_val), 0);
   endtask

   logic [WW-1:0] bm;
   int lat;

   initial begin
      rst_n      = 1'b0;
      req_val    = 1'b0;
      req_bitmap = '0;
      req_start  = '0;
      resp_rdy   = 1'b1;
      #12;
      chk("rst_rdy", int'(req_rdy), 1);
      chk("rst_val", int'(resp_val), 0);
      chk("rst_found", int'(resp_found), 0);
      chk("rst_ind", int'(resp_ind), 0);
      @(negedge clk);
      rst_n = 1'b1;

      bm = '0; bm[5] = 1'b1;
      run("bit5_s0", bm, 0, 2, 1, 5);

      bm = '0; bm[3] = 1'b1; bm[100] = 1'b1;
      run("bit3_100_s10", bm, 10, 8, 1, 100);

      bm = '0; bm[127] = 1'b1;
      run("bit127_s127", bm, 127, 2, 1, 127);

      bm = '0; bm[16] = 1'b1;
      run("bit16_s16", bm, 16, 2, 1, 16);

`ifdef FF_SEQ_WRAP_EN
      bm = '0; bm[3] = 1'b1;
      run("bit3_s10", bm, 10, 10, 1, 3);
      bm = '0;
      run("zero_s127", bm, 127, 10, 0, 0);
      bm = '0; bm[15] = 1'b1;
      run("bit15_s16", bm, 16, 9, 1, 15);
`else
      bm = '0; bm[3] = 1'b1;
      run("bit3_s10", bm, 10, 9, 0, 0);
      bm = '0;
      run("zero_s127", bm, 127, 2, 0, 0);
      bm = '0; bm[15] = 1'b1;
      run("bit15_s16", bm, 16, 8, 0, 0);
`endif

      // Backpressure: result held, new requests ignored while DONE.
      resp_rdy = 1'b0;
      bm = '0; bm[5] = 1'b1;
      issue(bm, 0);
      wait_resp(lat);
      chk("bp_lat", lat, 2);
      for (int i = 0; i < 5; i++) begin
         req_val    = 1'b1;
         req_bitmap = '0;
         req_bitmap[9] = 1'b1;
         @(posedge clk);
         #1;
         chk("bp_val", int'(resp_val), 1);
         chk("bp_found", int'(resp_found), 1);
         chk("bp_ind", int'(resp_ind), 5);
         chk("bp_rdy", int'(req_rdy), 0);
      end
      req_val  = 1'b0;
      resp_rdy = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_rdy_after", int'(req_rdy), 1);
      chk("bp_val_after", int'(resp_val), 0);

      // Reset during a 7-chunk search discards it.
      bm = '0; bm[100] = 1'b1;
      issue(bm, 10);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_val", int'(resp_val), 0);
      chk("rst_mid_rdy", int'(req_rdy), 1);
      chk("rst_mid_found", int'(resp_found), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_resp(lat);
      chk("rst_mid_no_resp", lat, 0);
      chk("rst_mid_rdy_after", int'(req_rdy), 1);

      bm = '0; bm[40] = 1'b1;
      run("post_rst_bit40_s0", bm, 0, 4, 1, 40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
